reg_access_arbiter: RTL and testbench

REG_ACCESS_ARBITER -- requirements
Module: reg_access_arbiter

---
 rtl/reg_access_arbiter_if.sv | 30 +++
 rtl/reg_access_arbiter.sv | 122 ++++++++++++
 tb/tb_reg_access_arbiter.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/reg_access_arbiter_if.sv
// Bus bundle between two requesters and the register-access arbiter.
// The arbiter drives the slave side; the requesters and the register sit on the master side.
interface reg_access_arbiter_if;
  logic        Req0;
  logic        Req1;
  logic [2:0]  Op0;
  logic [2:0]  Op1;
  logic [15:0] Data0;
  logic [15:0] Data1;
  logic [3:0]  Len0;
  logic [3:0]  Len1;
  logic        Ack0;
  logic        Ack1;
  logic        Gnt0;
  logic        Gnt1;
  logic        E;
  logic [2:0]  FunSel;
  logic [15:0] I;
  logic        Busy;

  modport slave (
    input  Req0, Req1, Op0, Op1, Data0, Data1, Len0, Len1,
    output Ack0, Ack1, Gnt0, Gnt1, E, FunSel, I, Busy
  );

  modport master (
    output Req0, Req1, Op0, Op1, Data0, Data1, Len0, Len1,
    input  Ack0, Ack1, Gnt0, Gnt1, E, FunSel, I, Busy
  );
endinterface

// File: rtl/reg_access_arbiter.sv
// Round-robin arbiter giving two requesters repeated access to one register.
// Every output is a flop, so no request-side input reaches an output combinationally.
module reg_access_arbiter (
  input  logic                 Clock,
  input  logic                 Reset,
  reg_access_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    ACK  = 2'd2
  } state_t;

  state_t      state;
  logic [3:0]  count;
  logic        ptr;
  logic        e_r;
  logic [2:0]  funsel_r;
  logic [15:0] i_r;
  logic        gnt0_r;
  logic        gnt1_r;
  logic        ack0_r;
  logic        ack1_r;
  logic        busy_r;

  logic        win;
  logic [2:0]  win_op;
  logic [15:0] win_data;
  logic [3:0]  win_len;

  // On a tie the requester that was not granted last wins.
  function automatic logic pick_winner(input logic r0, input logic r1, input logic last);
    if (r0 && r1) begin
      return ~last;
    end
    return r1 & ~r0;
  endfunction

  always_comb begin
    win      = pick_winner(bus.Req0, bus.Req1, ptr);
    win_op   = win ? bus.Op1   : bus.Op0;
    win_data = win ? bus.Data1 : bus.Data0;
    win_len  = win ? bus.Len1  : bus.Len0;
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state    <= IDLE;
      count    <= 4'd0;
      ptr      <= 1'b1;
      e_r      <= 1'b0;
      funsel_r <= 3'b000;
      i_r      <= 16'd0;
      gnt0_r   <= 1'b0;
      gnt1_r   <= 1'b0;
      ack0_r   <= 1'b0;
      ack1_r   <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          ack0_r <= 1'b0;
          ack1_r <= 1'b0;
          if (bus.Req0 || bus.Req1) begin
            state    <= EXEC;
            ptr      <= win;
            count    <= win_len;
            gnt0_r   <= ~win;
            gnt1_r   <= win;
            e_r      <= 1'b1;
            funsel_r <= win_op;
            i_r      <= win_data;
            busy_r   <= 1'b1;
          end
        end
        EXEC: begin
          // FunSel/I hold the values captured at grant time for the whole burst.
          if (count == 4'd0) begin
            state    <= ACK;
            e_r      <= 1'b0;
            funsel_r <= 3'b000;
            i_r      <= 16'd0;
            ack0_r   <= gnt0_r;
            ack1_r   <= gnt1_r;
          end else begin
            count <= count - 4'd1;
          end
        end
        ACK: begin
          state  <= IDLE;
          ack0_r <= 1'b0;
          ack1_r <= 1'b0;
          gnt0_r <= 1'b0;
          gnt1_r <= 1'b0;
          busy_r <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          e_r      <= 1'b0;
          funsel_r <= 3'b000;
          i_r      <= 16'd0;
          gnt0_r   <= 1'b0;
          gnt1_r   <= 1'b0;
          ack0_r   <= 1'b0;
          ack1_r   <= 1'b0;
          busy_r   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.E      = e_r;
  assign bus.FunSel = funsel_r;
  assign bus.I      = i_r;
  assign bus.Gnt0   = gnt0_r;
  assign bus.Gnt1   = gnt1_r;
  assign bus.Ack0   = ack0_r;
  assign bus.Ack1   = ack1_r;
  assign bus.Busy   = busy_r;

endmodule

// File: tb/tb_reg_access_arbiter.sv
// Directed bench for reg_access_arbiter with a simple 16-bit register model on the bus.
// Codes used: 000 decrement, 001 increment, 010 load, 011 clear.
module tb_reg_access_arbiter;

  logic        Clock = 1'b0;
  logic        Reset;
  logic [15:0] q;
  int          errors = 0;
  int          checks = 0;

  always #5 Clock = ~Clock;

  reg_access_arbiter_if bus();

  reg_access_arbiter dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  // Register with no reset, driven by the arbiter.
  always @(posedge Clock) begin
    if (bus.E) begin
      case (bus.FunSel)
        3'b000:  q <= q - 16'd1;
        3'b001:  q <= q + 16'd1;
        3'b010:  q <= bus.I;
        3'b011:  q <= 16'd0;
        default: q <= q;
      endcase
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int who, input logic r, input logic [2:0] op,
                         input logic [15:0] data, input logic [3:0] len);
    if (who == 0) begin
      bus.Req0 = r; bus.Op0 = op; bus.Data0 = data; bus.Len0 = len;
    end else begin
      bus.Req1 = r; bus.Op1 = op; bus.Data1 = data; bus.Len1 = len;
    end
  endtask

  // Issues one request and watches it until the arbiter returns to IDLE.
  // chg>0: after that many EXEC cycles, Op becomes 011 and Req drops.
  task automatic run_op(input string tag, input int who, input logic [2:0] op,
                        input logic [15:0] data, input logic [3:0] len, input int chg,
                        output int n_exec, output int n_busy, output int ack_at,
                        output int n_ack, output int bad);
    bit seen = 0;
    bit done = 0;
    logic own_ack, oth_ack, own_gnt, oth_gnt;
    n_exec = 0; n_busy = 0; ack_at = -1; n_ack = 0; bad = 0;
    set_req(who, 1'b1, op, data, len);
    for (int t = 1; t <= 40 && !done; t++) begin
      @(negedge Clock);
      own_ack = (who == 0) ? bus.Ack0 : bus.Ack1;
      oth_ack = (who == 0) ? bus.Ack1 : bus.Ack0;
      own_gnt = (who == 0) ? bus.Gnt0 : bus.Gnt1;
      oth_gnt = (who == 0) ? bus.Gnt1 : bus.Gnt0;
      if (bus.Busy) begin
        seen = 1;
        n_busy++;
        if (own_gnt !== 1'b1) bad++;
      end
      if (oth_gnt || oth_ack) bad++;
      if (bus.E) begin
        n_exec++;
        if (bus.FunSel !== op || bus.I !== data) bad++;
      end
      if (own_ack) begin
        n_ack++;
        if (ack_at < 0) ack_at = t;
        set_req(who, 1'b0, op, data, len);
      end
      if (chg > 0 && bus.E && n_exec == chg) set_req(who, 1'b0, 3'b011, ~data, 4'd0);
      if (seen && !bus.Busy) done = 1;
    end
    if (!done) begin
      checks++;
      errors++;
      $error("FAIL %s_timeout: observed=busy expected=idle", tag);
    end
  endtask

  int n_exec, n_busy, ack_at, n_ack, bad;
  int order [4];
  logic [15:0] ival [4];
  int ng, both_bad, a0, a1;

  initial begin
    Reset = 1'b1;
    set_req(0, 1'b0, 3'b000, 16'd0, 4'd0);
    set_req(1, 1'b0, 3'b000, 16'd0, 4'd0);
    repeat (2) @(negedge Clock);
    chk("rst_E",      {31'd0, bus.E},    32'd0);
    chk("rst_FunSel", {29'd0, bus.FunSel}, 32'd0);
    chk("rst_I",      {16'd0, bus.I},    32'd0);
    chk("rst_Gnt",    {30'd0, bus.Gnt1, bus.Gnt0}, 32'd0);
    chk("rst_Ack",    {30'd0, bus.Ack1, bus.Ack0}, 32'd0);
    chk("rst_Busy",   {31'd0, bus.Busy}, 32'd0);

    // Single load, issued on the cycle reset releases.
    Reset = 1'b0;
    run_op("load", 0, 3'b010, 16'hA5C3, 4'd0, 0, n_exec, n_busy, ack_at, n_ack, bad);
    chk("load_exec", n_exec, 1);
    chk("load_ackat", ack_at, 2);
    chk("load_nack", n_ack, 1);
    chk("load_busy", n_busy, 2);
    chk("load_bad", bad, 0);
    chk("load_q", {16'd0, q}, 32'h0000A5C3);

    // Repeat increment from 00FE.
    run_op("pre_fe", 1, 3'b010, 16'h00FE, 4'd0, 0, n_exec, n_busy, ack_at, n_ack, bad);
    chk("pre_fe_q", {16'd0, q}, 32'h000000FE);
    run_op("inc4", 1, 3'b001, 16'h0000, 4'd3, 0, n_exec, n_busy, ack_at, n_ack, bad);
    chk("inc4_exec", n_exec, 4);
    chk("inc4_ackat", ack_at, 5);
    chk("inc4_nack", n_ack, 1);
    chk("inc4_bad", bad, 0);
    chk("inc4_q", {16'd0, q}, 32'h00000102);

    // Op/Req changes mid-burst have no effect.
    run_op("pre_10", 0, 3'b010, 16'h0010, 4'd0, 0, n_exec, n_busy, ack_at, n_ack, bad);
    run_op("midop", 0, 3'b000, 16'h1234, 4'd15, 5, n_exec, n_busy, ack_at, n_ack, bad);
    chk("midop_exec", n_exec, 16);
    chk("midop_nack", n_ack, 1);
    chk("midop_bad", bad, 0);
    chk("midop_q", {16'd0, q}, 32'h00000000);

    // Longest burst with wrap-around.
    run_op("pre_05", 0, 3'b010, 16'h0005, 4'd0, 0, n_exec, n_busy, ack_at, n_ack, bad);
    run_op("wrap", 0, 3'b000, 16'h0000, 4'd15, 0, n_exec, n_busy, ack_at, n_ack, bad);
    chk("wrap_exec", n_exec, 16);
    chk("wrap_busy", n_busy, 17);
    chk("wrap_ackat", ack_at, 17);
    chk("wrap_bad", bad, 0);
    chk("wrap_q", {16'd0, q}, 32'h0000FFF5);

    // Continuous tie from reset: grants alternate starting at requester 0.
    Reset = 1'b1;
    @(negedge Clock);
    Reset = 1'b0;
    set_req(0, 1'b1, 3'b010, 16'h1111, 4'd0);
    set_req(1, 1'b1, 3'b010, 16'h2222, 4'd0);
    ng = 0; both_bad = 0; a0 = 0; a1 = 0;
    for (int t = 0; t < 12; t++) begin
      @(negedge Clock);
      if (bus.Gnt0 && bus.Gnt1) both_bad++;
      if (bus.Ack0 && bus.Ack1) both_bad++;
      if (bus.Ack0) a0++;
      if (bus.Ack1) a1++;
      if (bus.E && ng < 4) begin
        order[ng] = bus.Gnt1 ? 1 : 0;
        ival[ng]  = bus.I;
        ng++;
      end
    end
    set_req(0, 1'b0, 3'b000, 16'd0, 4'd0);
    set_req(1, 1'b0, 3'b000, 16'd0, 4'd0);
    chk("tie_ngrants", ng, 4);
    chk("tie_g0", order[0], 0);
    chk("tie_g1", order[1], 1);
    chk("tie_g2", order[2], 0);
    chk("tie_g3", order[3], 1);
    chk("tie_i1", {16'd0, ival[1]}, 32'h00002222);
    chk("tie_both", both_bad, 0);
    chk("tie_ack0", a0, 2);
    chk("tie_ack1", a1, 2);
    chk("tie_q", {16'd0, q}, 32'h00002222);

    // Reset during the second EXEC cycle of an 8-cycle burst.
    @(negedge Clock);
    set_req(0, 1'b1, 3'b001, 16'h0000, 4'd7);
    repeat (2) @(negedge Clock);
    chk("abort_pre_E", {31'd0, bus.E}, 32'd1);
    #2 Reset = 1'b1;
    #1;
    chk("abort_E", {31'd0, bus.E}, 32'd0);
    chk("abort_Busy", {31'd0, bus.Busy}, 32'd0);
    chk("abort_Gnt0", {31'd0, bus.Gnt0}, 32'd0);
    a0 = 0;
    for (int t = 0; t < 3; t++) begin
      @(negedge Clock);
      if (bus.Ack0 || bus.Ack1) a0++;
    end
    Reset = 1'b0;
    set_req(1, 1'b1, 3'b010, 16'h3333, 4'd0);
    @(negedge Clock);
    if (bus.Ack0 || bus.Ack1) a0++;
    chk("abort_noack", a0, 0);
    chk("rel_Gnt0", {31'd0, bus.Gnt0}, 32'd1);
    chk("rel_Gnt1", {31'd0, bus.Gnt1}, 32'd0);
    chk("rel_E", {31'd0, bus.E}, 32'd1);
    set_req(0, 1'b0, 3'b000, 16'd0, 4'd0);
    set_req(1, 1'b0, 3'b000, 16'd0, 4'd0);
    repeat (12) @(negedge Clock);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
